// File: rtl/decoder_seq.sv
// decoder_seq
//   Queues 3-bit binary codes in a small FIFO and plays each one out as a
//   one-hot byte, held for HOLD_CYCLES cycles, followed by one inactive gap
//   cycle before the next word.
//
// Parameters
//   HOLD_CYCLES  cycles each one-hot word is driven (1..15)
//   DEPTH        code FIFO depth in entries (power of 2, 2..16)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   en         block enable; when low, FSM, hold counter and FIFO freeze
//   in_valid   a code is offered on in_code
//   in_code    3-bit binary code to decode
//   in_ready   a code can be accepted this cycle
//   out        decoded one-hot word (inactive value when out_valid is low)
//   out_valid  out carries a decoded word
//   busy       FIFO non-empty or FSM not idle
//
// Configuration
//   DECODER_SEQ_ZOUT_EN  when defined, out floats (all z) whenever out_valid
//                        is low; otherwise out is driven to 8'h00.

module decoder_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      hold_cnt;
  logic [3:0]      hold_nxt;

  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      word;

  logic            push;
  logic            pop;
  logic            fifo_empty;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never makes room for a push (no bypass path).
  assign fifo_empty = (count == '0);
  assign in_ready   = en && (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;

  // The head leaves the FIFO exactly when the FSM starts a new word, which
  // can only happen from IDLE or GAP.
  assign pop = en && !fifo_empty && ((state == IDLE) || (state == GAP));

  // State register and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic. Nothing moves while en is low, so a stalled word
  // resumes with whatever hold count it had left.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state_nxt = DRIVE;
            hold_nxt  = 4'(HOLD_CYCLES - 1);
          end
        end
        DRIVE: begin
          if (hold_cnt == 4'd0) begin
            state_nxt = GAP;
          end else begin
            hold_nxt = hold_cnt - 4'd1;
          end
        end
        GAP: begin
          if (!fifo_empty) begin
            state_nxt = DRIVE;
            hold_nxt  = 4'(HOLD_CYCLES - 1);
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          hold_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    out_valid = (state == DRIVE) && en;
    busy      = !fifo_empty || (state != IDLE);
  end

  // FIFO pointers and occupancy. Pointers are AW bits wide and DEPTH is a
  // power of two, so incrementing wraps modulo DEPTH on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_code;
    end
  end

  // The decoded word is latched at the pop so the FIFO slot can be reused
  // while the word is still being held on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= 8'h00;
    end else if (pop) begin
      word <= 8'h01 << mem[rd_ptr];
    end
  end

`ifdef DECODER_SEQ_ZOUT_EN
  assign out = out_valid ? word : 8'bzzzzzzzz;
`else
  assign out = out_valid ? word : 8'h00;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq
//   Directed scoreboard bench for decoder_seq. Accepted codes push their
//   one-hot word onto a queue; a monitor on the falling edge pops a word
//   whenever a new output word starts and checks it for its full hold time,
//   followed by the inactive gap cycle.

module tb_decoder_seq;

  localparam int HOLD = 4;
  localparam int DEP  = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;

  int         assertions;
  int         failures;
  logic [7:0] expQ[$];
  logic [7:0] idleVal;

  // Monitor state: word currently being held and cycles still owed.
  logic [7:0] curWord;
  int         remaining;
  bit         gapExpected;

  decoder_seq #(
    .HOLD_CYCLES(HOLD),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in_valid(in_valid),
    .in_code(in_code),
    .in_ready(in_ready),
    .out(out),
    .out_valid(out_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DECODER_SEQ_ZOUT_EN
  initial idleVal = 8'bzzzzzzzz;
`else
  initial idleVal = 8'h00;
`endif

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Offer a code until it is accepted (bounded), recording its expected
  // word at the accepting edge. Leaves in_valid high; returns 1 time unit
  // after the accepting edge.
  task automatic applyStimulus(input logic [2:0] code);
    logic [7:0] one;
    bit got;
    one = 8'h01;
    got = 1'b0;
    in_code  = code;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        expQ.push_back(one << code);
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) begin
      checkOutput("push_timeout", 8'h01, 8'h00);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && expQ.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checkOutput("idle_timeout", 8'h01, 8'h00);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      remaining   = 0;
      gapExpected = 1'b0;
    end else if (out_valid === 1'b1) begin
      if (gapExpected && en === 1'b1) begin
        checkOutput("gap_cycle", {7'b0, out_valid}, 8'h00);
        gapExpected = 1'b0;
      end
      if (remaining == 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", {7'b0, out_valid}, 8'h00);
        end else begin
          curWord   = expQ.pop_front();
          remaining = HOLD;
        end
      end
      if (remaining != 0) begin
        checkOutput("word", out, curWord);
        remaining--;
        if (remaining == 0) begin
          gapExpected = 1'b1;
        end
      end
    end else begin
      if (gapExpected && en === 1'b1) begin
        checkOutput("gap_cycle", {7'b0, out_valid}, 8'h00);
        gapExpected = 1'b0;
      end
      if (en === 1'b1 && remaining != 0) begin
        checkOutput("word_cut_short", 8'(remaining), 8'h00);
        remaining = 0;
      end
      checkOutput("idle_out", out, idleVal);
    end
  end

  initial begin
    assertions  = 0;
    failures    = 0;
    remaining   = 0;
    gapExpected = 1'b0;
    curWord     = 8'h00;
    rst         = 1'b1;
    en          = 1'b1;
    in_valid    = 1'b0;
    in_code     = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    checkOutput("rst_in_ready", {7'b0, in_ready}, 8'h01);
    checkOutput("rst_out", out, idleVal);
    @(posedge clk);
    #1;

    // Single code 5: one idle cycle, 4 drive cycles, gap, then idle.
    applyStimulus(3'd5);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_before", {7'b0, out_valid}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_first_valid", {7'b0, out_valid}, 8'h01);
    checkOutput("lat_first_out", out, 8'b0010_0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("gap_busy", {7'b0, busy}, 8'h01);
    checkOutput("gap_out", out, idleVal);
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_busy", {7'b0, busy}, 8'h00);
    checkOutput("done_out", out, idleVal);
    @(posedge clk);
    #1;

    // Back-to-back codes 0, 7, 2.
    applyStimulus(3'd0);
    applyStimulus(3'd7);
    applyStimulus(3'd2);
    in_valid = 1'b0;
    waitIdle();

    // Stall code 6 after two drive cycles for three cycles.
    applyStimulus(3'd6);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", {7'b0, out_valid}, 8'h00);
      checkOutput("stall_out", out, idleVal);
      checkOutput("stall_busy", {7'b0, busy}, 8'h01);
      checkOutput("stall_ready", {7'b0, in_ready}, 8'h00);
      @(posedge clk);
    end
    #1;
    en = 1'b1;
    @(negedge clk);
    checkOutput("resume1_valid", {7'b0, out_valid}, 8'h01);
    checkOutput("resume1_out", out, 8'h40);
    @(negedge clk);
    checkOutput("resume2_valid", {7'b0, out_valid}, 8'h01);
    checkOutput("resume2_out", out, 8'h40);
    @(negedge clk);
    checkOutput("resume_gap", {7'b0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    waitIdle();

    // Continuous offers fill the FIFO: 4 queued plus 1 in drive.
    applyStimulus(3'd1);
    applyStimulus(3'd2);
    applyStimulus(3'd3);
    applyStimulus(3'd4);
    applyStimulus(3'd5);
    @(negedge clk);
    checkOutput("full_ready", {7'b0, in_ready}, 8'h00);
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    checkOutput("full_ready_en0", {7'b0, in_ready}, 8'h00);
    @(posedge clk);
    #1;
    en = 1'b1;
    applyStimulus(3'd6);
    applyStimulus(3'd7);
    in_valid = 1'b0;
    waitIdle();

    // Reset mid-drive with 3 codes queued and a push offered at the reset edge.
    applyStimulus(3'd1);
    applyStimulus(3'd2);
    applyStimulus(3'd3);
    applyStimulus(3'd4);
    in_code = 3'd7;
    doReset();
    @(negedge clk);
    checkOutput("midrst_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("midrst_busy", {7'b0, busy}, 8'h00);
    checkOutput("midrst_ready", {7'b0, in_ready}, 8'h01);
    repeat (20) @(posedge clk);
    #1;

    // in_ready follows en after reset release.
    en = 1'b0;
    doReset();
    @(negedge clk);
    checkOutput("rst_ready_en0", {7'b0, in_ready}, 8'h00);
    en = 1'b1;
    #1;
    checkOutput("rst_ready_en1", {7'b0, in_ready}, 8'h01);
    @(posedge clk);
    #1;

    // A last word after all that, to prove the block still works.
    applyStimulus(3'd3);
    in_valid = 1'b0;
    waitIdle();
    checkOutput("queue_drained", 8'(expQ.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
